// File: rtl/rmt_action_pkg.sv
// rtl/rmt_action_pkg.sv - shared widths and combined-bus field positions for the RMT action stage
package rmt_action_pkg;

  localparam int CONT_LEN_DEF = 768;
  localparam int META_LEN_DEF = 256;
  localparam int COMP_LEN_DEF = 100;

  // Positions inside the combined {meta, comp} bus as written by the metadata ALU
  localparam int DISCARD_BIT = 128;
  localparam int NTID_MSB    = 355;
  localparam int NTID_W      = 6;

  // Merged PHV width for a given container / combined-metadata split
  function automatic int phv_len(input int cont_len, input int cm_len);
    return cont_len + cm_len;
  endfunction

endpackage

// File: rtl/action_phv_merge_if.sv
// rtl/action_phv_merge_if.sv - ALU result inputs and merged PHV handshake bundle
interface action_phv_merge_if #(
  parameter int CONT_LEN = 768,
  parameter int CM_LEN   = 356
);
  import rmt_action_pkg::*;

  logic [CONT_LEN-1:0]        cont_data_in;
  logic                       cont_data_valid_in;
  logic [CM_LEN-1:0]          comp_meta_data_in;
  logic                       comp_meta_data_valid_in;
  logic [CONT_LEN+CM_LEN-1:0] phv_out;
  logic                       phv_valid_out;
  logic                       phv_ready_in;
  logic                       discard_out;
  logic [NTID_W-1:0]          next_table_id_out;

  // Upstream ALUs and downstream stage side
  modport master (
    output cont_data_in, cont_data_valid_in, comp_meta_data_in, comp_meta_data_valid_in,
    output phv_ready_in,
    input  phv_out, phv_valid_out, discard_out, next_table_id_out
  );

  // Merge block side
  modport slave (
    input  cont_data_in, cont_data_valid_in, comp_meta_data_in, comp_meta_data_valid_in,
    input  phv_ready_in,
    output phv_out, phv_valid_out, discard_out, next_table_id_out
  );

endinterface

// File: rtl/merge_fifo.sv
// rtl/merge_fifo.sv - first-word-fall-through alignment FIFO with pop-then-write on full
module merge_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             rd_ok;
  logic             wr_ok;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];
  assign rd_ok = pop && !empty;
  // A full FIFO still takes a write when the head leaves in the same cycle
  assign wr_ok = push && (!full || rd_ok);

  // Storage array; contents are don't-care until count covers them, so no reset
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/action_phv_merge.sv
// rtl/action_phv_merge.sv - aligns container and metadata ALU results into one PHV per pair
module action_phv_merge
  import rmt_action_pkg::*;
#(
  parameter int STAGE    = 0,
  parameter int CONT_LEN = CONT_LEN_DEF,
  parameter int META_LEN = META_LEN_DEF,
  parameter int COMP_LEN = COMP_LEN_DEF,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  action_phv_merge_if.slave   bus,
  output logic                almost_full_out,
  output logic [31:0]         pair_cnt_out,
  output logic [31:0]         discard_cnt_out,
  output logic                ovf_err_out
);

  localparam int CM_LEN  = META_LEN + COMP_LEN;
  localparam int PHV_LEN = phv_len(CONT_LEN, CM_LEN);
  localparam int CW      = $clog2(DEPTH + 1);

  logic [CONT_LEN-1:0] cont_head;
  logic [CM_LEN-1:0]   meta_head;
  logic                cont_full, cont_empty;
  logic                meta_full, meta_empty;
  logic [CW-1:0]       cont_count, meta_count;
  logic                pop;
  logic                xfer;
  logic [PHV_LEN-1:0]  phv_q;
  logic                valid_q;

  // Pairs leave together whenever the output slot is free or is being emptied
  assign pop  = !cont_empty && !meta_empty && (!valid_q || bus.phv_ready_in);
  assign xfer = valid_q && bus.phv_ready_in;

  merge_fifo #(.WIDTH(CONT_LEN), .DEPTH(DEPTH)) u_cont_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (bus.cont_data_valid_in),
    .push_data (bus.cont_data_in),
    .pop       (pop),
    .head      (cont_head),
    .full      (cont_full),
    .empty     (cont_empty),
    .count     (cont_count)
  );

  merge_fifo #(.WIDTH(CM_LEN), .DEPTH(DEPTH)) u_meta_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (bus.comp_meta_data_valid_in),
    .push_data (bus.comp_meta_data_in),
    .pop       (pop),
    .head      (meta_head),
    .full      (meta_full),
    .empty     (meta_empty),
    .count     (meta_count)
  );

  // Output register: load a new pair, or go idle once the held PHV is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phv_q   <= '0;
      valid_q <= 1'b0;
    end else if (pop) begin
      phv_q   <= {cont_head, meta_head};
      valid_q <= 1'b1;
    end else if (xfer) begin
      valid_q <= 1'b0;
    end
  end

  // Hand-off statistics, free-running modulo 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_cnt_out    <= '0;
      discard_cnt_out <= '0;
    end else if (xfer) begin
      pair_cnt_out <= pair_cnt_out + 32'd1;
      if (phv_q[DISCARD_BIT]) discard_cnt_out <= discard_cnt_out + 32'd1;
    end
  end

  // Sticky overflow: a strobe arrived while its FIFO was full and nothing left
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_err_out <= 1'b0;
    end else if ((bus.cont_data_valid_in && cont_full && !pop) ||
                 (bus.comp_meta_data_valid_in && meta_full && !pop)) begin
      ovf_err_out <= 1'b1;
    end
  end

  assign almost_full_out       = (cont_count >= CW'(DEPTH - 1)) || (meta_count >= CW'(DEPTH - 1));
  assign bus.phv_out           = phv_q;
  assign bus.phv_valid_out     = valid_q;
  assign bus.discard_out       = phv_q[DISCARD_BIT];
  assign bus.next_table_id_out = phv_q[NTID_MSB -: NTID_W];

endmodule
